// File: rtl/octave_sequencer.sv
// Frame sequencer for the octave pyramid datapath: it forwards one frame of source pixels,
// then emits blanking rows to drain the Gaussian/difference pipeline, then pulses frame_done.
module octave_sequencer #(
  parameter int WIDTH      = 420,
  parameter int HEIGHT     = 240,
  parameter int FLUSH_ROWS = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] oct_din,
  output logic              oct_validin,
  output logic              oct_blanking,
  output logic              busy,
  output logic              frame_done,
  output logic [8:0]        row,
  output logic [8:0]        col
);

  // WIDTH, HEIGHT and FLUSH_ROWS must each be 1..512 so that indices fit the 9-bit counters.
  localparam logic [8:0] COL_LAST       = 9'(WIDTH - 1);
  localparam logic [8:0] ROW_LAST_FEED  = 9'(HEIGHT - 1);
  localparam logic [8:0] ROW_LAST_FLUSH = 9'(FLUSH_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  logic   accept;

  assign src_ready = (state == S_FEED);
  assign accept    = src_valid & src_ready;

  // Stage p0 -> outputs: every beat is registered, so oct_* trails acceptance by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      oct_din      <= '0;
      oct_validin  <= 1'b0;
      oct_blanking <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      row          <= '0;
      col          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          oct_validin  <= 1'b0;
          oct_blanking <= 1'b0;
          frame_done   <= 1'b0;
          if (start) begin
            state <= S_FEED;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end

        S_FEED: begin
          oct_validin  <= accept;
          oct_blanking <= 1'b0;
          if (accept) begin
            oct_din <= src_data;
          end
          // An abort still lets a beat accepted in the same cycle through.
          if (abort) begin
            state <= S_FLUSH;
            row   <= '0;
            col   <= '0;
          end else if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST_FEED) begin
                state <= S_FLUSH;
                row   <= '0;
              end else begin
                row <= row + 9'd1;
              end
            end else begin
              col <= col + 9'd1;
            end
          end
        end

        S_FLUSH: begin
          oct_validin  <= 1'b1;
          oct_blanking <= 1'b1;
          oct_din      <= '0;
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST_FLUSH) begin
              state <= S_DONE;
              busy  <= 1'b0;
              row   <= '0;
            end else begin
              row <= row + 9'd1;
            end
          end else begin
            col <= col + 9'd1;
          end
        end

        S_DONE: begin
          oct_validin  <= 1'b0;
          oct_blanking <= 1'b0;
          frame_done   <= 1'b1;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_octave_sequencer.sv
// Directed bench for octave_sequencer (4x3 frame, 2 flush rows): a beat-counting model is
// compared every cycle, and each scenario is also pinned by hand-computed totals.
module tb_octave_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FR = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] oct_din;
  logic       oct_validin;
  logic       oct_blanking;
  logic       busy;
  logic       frame_done;
  logic [8:0] row;
  logic [8:0] col;

  int total = 0;
  int bad   = 0;

  octave_sequencer #(.WIDTH(W), .HEIGHT(H), .FLUSH_ROWS(FR), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .oct_din(oct_din), .oct_validin(oct_validin), .oct_blanking(oct_blanking),
    .busy(busy), .frame_done(frame_done), .row(row), .col(col)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s at t=%0t: got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  // Model: phase 0 idle, 1 feeding, 2 flushing, 3 done; position derived from beat counts.
  int         ph    = 0;
  int         n_acc = 0;
  int         n_blk = 0;
  bit         armed = 0;
  logic [7:0] e_din = '0;
  logic       e_val = 0, e_blk = 0, e_busy = 0, e_done = 0;
  logic [8:0] e_row = '0, e_col = '0;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        ph = 0; e_din = '0; e_val = 0; e_blk = 0; e_busy = 0; e_done = 0;
        e_row = '0; e_col = '0; armed = 1;
      end else begin
        case (ph)
          0: begin
            e_val = 0; e_blk = 0; e_done = 0;
            if (start) begin
              ph = 1; n_acc = 0; e_row = '0; e_col = '0; e_busy = 1;
            end
          end
          1: begin
            if (src_valid) begin
              e_din = src_data; e_val = 1; e_blk = 0; n_acc = n_acc + 1;
            end else begin
              e_val = 0;
            end
            if (abort || n_acc == W * H) begin
              ph = 2; n_blk = 0; e_row = '0; e_col = '0;
            end else begin
              e_row = 9'(n_acc / W); e_col = 9'(n_acc % W);
            end
          end
          2: begin
            e_val = 1; e_blk = 1; e_din = '0; n_blk = n_blk + 1;
            if (n_blk == FR * W) begin
              ph = 3; e_busy = 0; e_row = '0; e_col = '0;
            end else begin
              e_row = 9'(n_blk / W); e_col = 9'(n_blk % W);
            end
          end
          default: begin
            e_done = 1; e_val = 0; e_blk = 0; ph = 0;
          end
        endcase
      end
      @(negedge clock);
      if (armed) begin
        cmp("src_ready", int'(src_ready), int'(ph == 1));
        cmp("oct_validin", int'(oct_validin), int'(e_val));
        cmp("oct_blanking", int'(oct_blanking), int'(e_blk));
        cmp("oct_din", int'(oct_din), int'(e_din));
        cmp("busy", int'(busy), int'(e_busy));
        cmp("frame_done", int'(frame_done), int'(e_done));
        cmp("row", int'(row), int'(e_row));
        cmp("col", int'(col), int'(e_col));
      end
    end
  end

  // Per-frame observations, recorded at negedges by run_frame.
  logic [7:0] nb_q[$];
  int nblank, ndone, nb_first, nb_last;
  bit saw23;

  task automatic run_frame(input bit stall, input int abort_on, input bit noise, input int rst_blank);
    int pix;
    bit tog, stop, rst_pending;
    nb_q.delete();
    nblank = 0; ndone = 0; saw23 = 0; nb_first = -1; nb_last = -1;
    pix = 1; tog = 1; stop = 0; rst_pending = 0;
    @(negedge clock);
    start = 1'b1;
    for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      if (rst_pending) begin
        cmp("rst_validin", int'(oct_validin), 0);
        cmp("rst_blanking", int'(oct_blanking), 0);
        cmp("rst_din", int'(oct_din), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_done", int'(frame_done), 0);
        cmp("rst_rowcol", int'({row, col}), 0);
        reset = 1'b0;
        stop = 1;
      end
      if (oct_validin && !oct_blanking) begin
        nb_q.push_back(oct_din);
        if (nb_first < 0) nb_first = cyc;
        nb_last = cyc;
      end
      if (oct_validin && oct_blanking) begin
        nblank = nblank + 1;
        if (rst_blank > 0 && nblank == rst_blank) begin
          reset = 1'b1;
          rst_pending = 1;
        end
      end
      if (frame_done) begin
        ndone = ndone + 1;
        cmp("busy_after_done", int'(busy), 0);
        stop = 1;
      end
      if (src_ready && row == 9'd2 && col == 9'd3) saw23 = 1;
      if (!stop) begin
        src_valid = stall ? tog : 1'b1;
        tog = ~tog;
        src_data = 8'(pix);
        if (abort_on > 0 && pix == abort_on && src_valid && src_ready) abort = 1'b1;
        if (noise && tog) start = 1'b1;
        if (noise && tog && pix > W * H) abort = 1'b1;
        if (src_valid && src_ready) pix = pix + 1;
      end
    end
    src_valid = 1'b0; start = 1'b0; abort = 1'b0;
    if (!stop) cmp("frame_timeout", 0, 1);
  endtask

  task automatic check_full_frame(input string tag);
    bit ok;
    ok = (nb_q.size() == W * H);
    for (int i = 0; i < nb_q.size(); i++) if (nb_q[i] != 8'(i + 1)) ok = 0;
    cmp({tag, "_pixels_1_to_12"}, int'(ok), 1);
    cmp({tag, "_blank_beats"}, nblank, 8);
    cmp({tag, "_done_pulses"}, ndone, 1);
  endtask

  initial begin
    int extra;
    reset = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
    repeat (2) @(negedge clock);
    cmp("reset_validin", int'(oct_validin), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_ready", int'(src_ready), 0);
    cmp("reset_done", int'(frame_done), 0);
    cmp("reset_rowcol", int'({row, col}), 0);
    cmp("reset_din", int'(oct_din), 0);
    // start and abort together while held in reset must not launch a frame
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    cmp("reset_priority_busy", int'(busy), 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clock);

    run_frame(0, 0, 0, 0);
    check_full_frame("stream");
    cmp("stream_contiguous", nb_last - nb_first, 11);
    repeat (2) @(negedge clock);

    run_frame(1, 0, 0, 0);
    check_full_frame("stall");
    cmp("stall_gaps_span", nb_last - nb_first, 22);
    cmp("stall_reached_2_3", int'(saw23), 1);
    repeat (2) @(negedge clock);

    run_frame(0, 5, 0, 0);
    cmp("abort_pixel_count", nb_q.size(), 5);
    cmp("abort_pixel5_fwd", (nb_q.size() == 5) ? int'(nb_q[4]) : -1, 5);
    cmp("abort_blank_beats", nblank, 8);
    cmp("abort_done_pulses", ndone, 1);
    repeat (2) @(negedge clock);

    run_frame(0, 0, 1, 0);
    check_full_frame("noise");
    repeat (2) @(negedge clock);

    run_frame(0, 0, 0, 3);
    cmp("rstflush_blank_beats", nblank, 3);
    cmp("rstflush_done_pulses", ndone, 0);
    extra = 0;
    repeat (12) begin
      @(negedge clock);
      if (frame_done || busy) extra = extra + 1;
    end
    cmp("rstflush_stays_idle", extra, 0);

    run_frame(0, 0, 0, 0);
    check_full_frame("after_reset");
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
